// File: rtl/mc_ctrl.sv
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle MIPS-subset main controller (FSM + decode).
//             Optional memory wait states enabled by defining MC_MEMWAIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef EXT_ZERO
`define EXT_ZERO    2'd0
`endif
`ifndef EXT_SIGNED
`define EXT_SIGNED  2'd1
`endif
`ifndef EXT_HIGHPOS
`define EXT_HIGHPOS 2'd2
`endif

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic       RegDst,
    output logic       WDSel,
    output logic [1:0] NPCOp,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_ADDIU = 6'h09;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_J     = 6'h02;

    localparam logic [5:0] C_FN_ADDU  = 6'h21;
    localparam logic [5:0] C_FN_SUBU  = 6'h23;
    localparam logic [5:0] C_FN_AND   = 6'h24;
    localparam logic [5:0] C_FN_OR    = 6'h25;
    localparam logic [5:0] C_FN_SLT   = 6'h2A;

    localparam logic [2:0] C_ALU_ADD  = 3'd0;
    localparam logic [2:0] C_ALU_SUB  = 3'd1;
    localparam logic [2:0] C_ALU_AND  = 3'd2;
    localparam logic [2:0] C_ALU_OR   = 3'd3;
    localparam logic [2:0] C_ALU_SLT  = 3'd4;

    localparam logic [1:0] C_NPC_SEQ  = 2'd0;
    localparam logic [1:0] C_NPC_BR   = 2'd1;
    localparam logic [1:0] C_NPC_JMP  = 2'd2;

    state_t     r_state_q;
    state_t     w_state_d;

    logic       w_rtype_ok;
    logic [2:0] w_rtype_aluop;
    logic       w_is_ialu;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_j;
    logic [2:0] w_exec_aluop;
    logic       w_mem_go;

    logic       w_pcwr;
    logic       w_irwr;
    logic       w_rfwr;
    logic       w_dmwr;
    logic [2:0] w_aluop;
    logic       w_alusrcb;
    logic       w_regdst;
    logic       w_wdsel;
    logic [1:0] w_npcop;
    logic       w_retire;
    logic       w_illegal;

`ifdef MC_MEMWAIT_EN
    assign w_mem_go = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_go           = 1'b1;
`endif

    // Instruction class decode; Op/Funct are stable once the IR has been loaded.
    always_comb begin
        w_rtype_ok    = 1'b1;
        w_rtype_aluop = C_ALU_ADD;
        unique case (Funct)
            C_FN_ADDU: w_rtype_aluop = C_ALU_ADD;
            C_FN_SUBU: w_rtype_aluop = C_ALU_SUB;
            C_FN_AND:  w_rtype_aluop = C_ALU_AND;
            C_FN_OR:   w_rtype_aluop = C_ALU_OR;
            C_FN_SLT:  w_rtype_aluop = C_ALU_SLT;
            default:   w_rtype_ok    = 1'b0;
        endcase
    end

    assign w_is_ialu = (Op == C_OP_ADDIU) || (Op == C_OP_ORI) || (Op == C_OP_LUI);
    assign w_is_lw   = (Op == C_OP_LW);
    assign w_is_sw   = (Op == C_OP_SW);
    assign w_is_beq  = (Op == C_OP_BEQ);
    assign w_is_j    = (Op == C_OP_J);

    always_comb begin
        w_exec_aluop = C_ALU_ADD;
        if (Op == C_OP_RTYPE) begin
            w_exec_aluop = w_rtype_aluop;
        end else if (Op == C_OP_ORI) begin
            w_exec_aluop = C_ALU_OR;
        end
    end

    always_comb begin
        EXTOp = `EXT_SIGNED;
        if (Op == C_OP_ORI) begin
            EXTOp = `EXT_ZERO;
        end else if (Op == C_OP_LUI) begin
            EXTOp = `EXT_HIGHPOS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_FETCH;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_pcwr    = 1'b0;
        w_irwr    = 1'b0;
        w_rfwr    = 1'b0;
        w_dmwr    = 1'b0;
        w_aluop   = C_ALU_ADD;
        w_alusrcb = 1'b0;
        w_regdst  = 1'b0;
        w_wdsel   = 1'b0;
        w_npcop   = C_NPC_SEQ;
        w_retire  = 1'b0;
        w_illegal = 1'b0;

        unique case (r_state_q)
            S_FETCH: begin
                if (w_mem_go) begin
                    w_irwr    = 1'b1;
                    w_pcwr    = 1'b1;
                    w_state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (((Op == C_OP_RTYPE) && w_rtype_ok) || w_is_ialu) begin
                    w_state_d = S_EXEC;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_d = S_MEMADR;
                end else if (w_is_beq) begin
                    w_state_d = S_BRANCH;
                end else if (w_is_j) begin
                    w_state_d = S_JUMP;
                end else begin
                    w_illegal = 1'b1;
                    w_state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                w_aluop   = w_exec_aluop;
                w_alusrcb = w_is_ialu;
                w_state_d = S_ALUWB;
            end
            // ALU controls held so the result stays valid through write-back.
            S_ALUWB: begin
                w_aluop   = w_exec_aluop;
                w_alusrcb = w_is_ialu;
                w_rfwr    = 1'b1;
                w_regdst  = (Op == C_OP_RTYPE);
                w_retire  = 1'b1;
                w_state_d = S_FETCH;
            end
            S_MEMADR: begin
                w_alusrcb = 1'b1;
                w_state_d = w_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (w_mem_go) begin
                    w_state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_rfwr    = 1'b1;
                w_wdsel   = 1'b1;
                w_retire  = 1'b1;
                w_state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (w_mem_go) begin
                    w_dmwr    = 1'b1;
                    w_retire  = 1'b1;
                    w_state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_aluop   = C_ALU_SUB;
                w_npcop   = C_NPC_BR;
                w_pcwr    = Zero;
                w_retire  = 1'b1;
                w_state_d = S_FETCH;
            end
            S_JUMP: begin
                w_npcop   = C_NPC_JMP;
                w_pcwr    = 1'b1;
                w_retire  = 1'b1;
                w_state_d = S_FETCH;
            end
            default: begin
                w_state_d = S_FETCH;
            end
        endcase
    end

    // Side-effecting strobes are suppressed for the whole time reset is high.
    assign PCWr    = w_pcwr    & ~rst;
    assign IRWr    = w_irwr    & ~rst;
    assign RFWr    = w_rfwr    & ~rst;
    assign DMWr    = w_dmwr    & ~rst;
    assign retire  = w_retire  & ~rst;
    assign illegal = w_illegal & ~rst;
    assign ALUOp   = w_aluop;
    assign ALUSrcB = w_alusrcb;
    assign RegDst  = w_regdst;
    assign WDSel   = w_wdsel;
    assign NPCOp   = w_npcop;

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port Op  in  6  opcode, IR[31:26]; stable from cycle after IRWr.
REQ-004 SHALL have port Funct  in  6  function field, IR[5:0].
REQ-005 SHALL have port Zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access complete; used only with MC_MEMWAIT_EN.
REQ-007 SHALL have ports PCWr, IRWr, RFWr, DMWr  out  1 each  PC, IR, register file and data memory write enables.
REQ-008 SHALL have port EXTOp  out  2  immediate-extender mode, values from shared `EXT_ZERO/`EXT_SIGNED/`EXT_HIGHPOS defines.
REQ-009 SHALL have port ALUOp  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
REQ-010 SHALL have ports ALUSrcB  out  1  (1 = Imm32); RegDst  out  1  (1 = rd); WDSel  out  1  (1 = memory data).
REQ-011 SHALL have port NPCOp  out  2  0 PC+4, 1 branch target, 2 jump target.
REQ-012 SHALL have ports retire  out  1  one-cycle pulse on an instruction's last state; illegal  out  1  one-cycle pulse on an unsupported opcode/funct.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP.
REQ-014 SHALL, in FETCH: IRWr=1, PCWr=1, NPCOp=0; next state DECODE.
REQ-015 SHALL, in DECODE, dispatch on Op: 0x00 (funct 0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2A slt), 0x09 addiu, 0x0D ori, 0x0F lui -> EXEC; 0x23 lw, 0x2B sw -> MEMADR; 0x04 beq -> BRANCH; 0x02 j -> JUMP; else -> FETCH with illegal=1.
REQ-016 SHALL set EXTOp: addiu/lw/sw/beq SIGNED, ori ZERO, lui HIGHPOS; ALUSrcB=1 for I-type EXEC and MEMADR.
REQ-017 SHALL assert in ALUWB RFWr=1, WDSel=0, RegDst=1 for R-type (0 for I-type), retire=1; next FETCH.
REQ-018 SHALL proceed MEMADR -> MEMRD (lw) or MEMWR (sw); MEMRD -> MEMWB; MEMWB: RFWr=1, WDSel=1, RegDst=0, retire=1; MEMWR: DMWr=1, retire=1; both -> FETCH.
REQ-019 SHALL, in BRANCH: ALUOp=1, NPCOp=1, PCWr=Zero, retire=1; in JUMP: NPCOp=2, PCWr=1, retire=1; both -> FETCH.
REQ-020 SHALL hold write enables, retire and illegal at 0 in every state not listed above as asserting them.
REQ-021 SHALL produce outputs combinationally from current state, Op, Funct, Zero (and mem_ready); no output latency beyond state register.
REQ-022 SHALL give cycle counts: R/I ALU 4, lw 5, sw 4, beq 3, j 3, illegal 2 (without wait states).

Reset
REQ-023 SHALL on rst=1 force state to FETCH immediately, independent of clk, including mid-instruction.
REQ-024 SHALL hold all write enables, retire and illegal at 0 while rst=1; first FETCH actions occur on first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with MC_MEMWAIT_EN defined, hold FETCH, MEMRD and MEMWR while mem_ready=0, asserting IRWr/PCWr (FETCH), DMWr and retire (MEMWR) only in the cycle mem_ready=1, and advance on that cycle.
REQ-026 SHALL, without MC_MEMWAIT_EN, ignore mem_ready and leave each of those states after exactly one cycle.

Verification
REQ-027 SHALL test reset mid-lw (assert rst in MEMRD) -> state FETCH, RFWr=0, no retire; normal fetch after release.
REQ-028 SHALL test Op=0x00 Funct=0x23 -> FETCH,DECODE,EXEC(ALUOp=1),ALUWB(RFWr=1,RegDst=1), retire in cycle 4.
REQ-029 SHALL test Op=0x0F -> EXTOp=`EXT_HIGHPOS in EXEC, RFWr=1 RegDst=0 in ALUWB.
REQ-030 SHALL test beq with Zero=0 then Zero=1 -> PCWr=0 then PCWr=1 with NPCOp=1 in BRANCH.
REQ-031 SHALL test Op=0x3F -> illegal=1 in DECODE, no write enables, FETCH next cycle.
REQ-032 SHALL test with MC_MEMWAIT_EN: sw, mem_ready low 3 cycles in MEMWR -> DMWr=0 for 3 cycles, DMWr=1 and retire=1 on cycle 4.
